gray_counter_param: RTL and testbench

Parametrised Gray-code counter, the next generation of the fixed 8-bit enable-only Gray counter. Adds configurable width, up/down counting, synchronous binary load, wrap or saturate at the terminal value, a terminal-count flag and an optional single-bit-change checker. It is the registered pointer/sequence source for clock-domain-crossing FIFOs, and a low-toggle position counter elsewhere in the design.

---
 rtl/gray_pkg.sv | 30 +++
 rtl/gray_adj_checker.sv | 47 ++++
 rtl/gray_counter_param.sv | 114 +++++++++++
 tb/tb_gray_counter_param.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for the parametrised Gray-code counter family.
//   GRAY_MAX_W : widest counter the helper functions support
//   dir_e      : counting direction encoding (DIR_DOWN=0, DIR_UP=1)
//   bin2gray   : binary to reflected Gray code
//   gray2bin   : reflected Gray code back to binary (prefix XOR)
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// gray_adj_checker
// Watches a registered Gray-code bus and flags any update that flips more
// than one bit, except updates caused by a load.  The flag is sticky until
// reset.  A hold (zero bits changed) is legal.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears history and flag
//   out    : Gray-code bus being watched
//   load_d : high when the edge that produced the current out was a load
//   err    : sticky adjacency-violation flag
module gray_adj_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] out,
    input  logic             load_d,
    output logic             err
);

    logic [WIDTH-1:0] prevOut_q;
    logic             err_q;
    logic             tooManyFlips;

    // Compare the current word against the one from the previous cycle.
    always_comb begin
        tooManyFlips = ($countones(out ^ prevOut_q) > 1);
    end

    // History register plus the sticky flag; a load legitimately jumps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevOut_q <= '0;
            err_q     <= 1'b0;
        end else begin
            prevOut_q <= out;
            if (!load_d && tooManyFlips) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: rtl/gray_counter_param.sv
// gray_counter_param
// Parametrised up/down Gray-code counter with synchronous binary load,
// wrap or saturate at the terminal value, a combinational terminal-count
// flag and an optional single-bit-change checker.
// Parameters:
//   WIDTH    : counter width (>= 2, <= 64)
//   SATURATE : 0 = wrap at terminal value, 1 = hold at terminal value
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   enable   : count one step per clock while high
//   up_down  : 1 = up, 0 = down
//   load     : synchronous load strobe, overrides enable
//   load_val : binary value to load
//   out      : registered Gray code of the count
//   bin_out  : registered binary count
//   tc       : terminal-count flag (combinational)
//   err      : sticky adjacency violation flag
// Optional feature: define GRAY_CNT_ADJ_CHECK_EN to build the adjacency
// checker; otherwise err is tied low.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             err
);

    dir_e             dir;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] termValue;
    logic             atTerminal;

    assign dir = dir_e'(up_down);

    // Terminal value depends on the direction currently requested.
    always_comb begin
        termValue  = (dir == DIR_UP) ? '1 : '0;
        atTerminal = (bin_q == termValue);
    end

    // Next binary count: load beats enable, enable beats hold.  In saturate
    // mode the terminal value is sticky until the direction reverses.
    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_val;
        end else if (enable) begin
            if ((SATURATE != 0) && atTerminal) begin
                bin_d = bin_q;
            end else if (dir == DIR_UP) begin
                bin_d = bin_q + WIDTH'(1);
            end else begin
                bin_d = bin_q - WIDTH'(1);
            end
        end
        out_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    // The Gray word is computed from the next binary value and registered
    // alongside it, so out never has combinational logic in front of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q <= '0;
            out_q <= '0;
        end else begin
            bin_q <= bin_d;
            out_q <= out_d;
        end
    end

    assign out     = out_q;
    assign bin_out = bin_q;
    assign tc      = enable & ~load & atTerminal;

`ifdef GRAY_CNT_ADJ_CHECK_EN
    logic loadSeen_q;

    // Remember whether the last edge was a load so its jump is excused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadSeen_q <= 1'b0;
        end else begin
            loadSeen_q <= load;
        end
    end

    gray_adj_checker #(
        .WIDTH (WIDTH)
    ) u_adj_checker (
        .clk    (clk),
        .reset  (reset),
        .out    (out_q),
        .load_d (loadSeen_q),
        .err    (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// tb_gray_counter_param
// Directed bench for gray_counter_param.  Two instances share the stimulus:
// dutWrap (SATURATE=0) and dutSat (SATURATE=1).  Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns after the edge or after inputs settle.
module tb_gray_counter_param;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       upDown;
    logic       load;
    logic [7:0] loadVal;

    logic [7:0] outW, binW, outS, binS;
    logic       tcW, errW, tcS, errS;

    int total = 0;
    int bad   = 0;

    gray_counter_param #(.WIDTH(8), .SATURATE(0)) dutWrap (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown),
        .load(load), .load_val(loadVal),
        .out(outW), .bin_out(binW), .tc(tcW), .err(errW)
    );

    gray_counter_param #(.WIDTH(8), .SATURATE(1)) dutSat (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown),
        .load(load), .load_val(loadVal),
        .out(outS), .bin_out(binS), .tc(tcS), .err(errS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; upDown = 1'b1; load = 1'b0; loadVal = 8'h00;
        #12;
        total++; if (outW !== 8'h00) begin bad++; $display("[TB] FAIL reset_out got=%h exp=00", outW); end
        total++; if (binW !== 8'h00) begin bad++; $display("[TB] FAIL reset_bin got=%h exp=00", binW); end
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL reset_tc got=%b exp=0", tcW); end
        total++; if (errW !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", errW); end
        total++; if (binS !== 8'h00) begin bad++; $display("[TB] FAIL reset_sat_bin got=%h exp=00", binS); end
        reset = 1'b0;
    endtask

    task automatic test_count_up();
        logic [7:0] prev;
        enable = 1'b1; upDown = 1'b1;
        #1;
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL up_tc_at0 got=%b exp=0", tcW); end
        for (int i = 1; i <= 10; i++) begin
            prev = outW;
            stepEdge();
            total++; if (binW !== 8'(i)) begin bad++; $display("[TB] FAIL up_bin step=%0d got=%h exp=%h", i, binW, 8'(i)); end
            total++; if ($countones(outW ^ prev) != 1) begin bad++; $display("[TB] FAIL up_onebit step=%0d got=%h prev=%h", i, outW, prev); end
        end
        total++; if (binW !== 8'h0A) begin bad++; $display("[TB] FAIL up10_bin got=%h exp=0a", binW); end
        total++; if (outW !== 8'h0F) begin bad++; $display("[TB] FAIL up10_out got=%h exp=0f", outW); end
    endtask

    task automatic test_hold();
        enable = 1'b0;
        #1;
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL hold_tc got=%b exp=0", tcW); end
        repeat (5) stepEdge();
        total++; if (outW !== 8'h0F) begin bad++; $display("[TB] FAIL hold_out got=%h exp=0f", outW); end
        total++; if (binW !== 8'h0A) begin bad++; $display("[TB] FAIL hold_bin got=%h exp=0a", binW); end
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL hold_tc_end got=%b exp=0", tcW); end
    endtask

    task automatic test_load_wrap();
        load = 1'b1; loadVal = 8'hFF; enable = 1'b1; upDown = 1'b1;
        #1;
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL load_blocks_tc got=%b exp=0", tcW); end
        stepEdge();
        total++; if (binW !== 8'hFF) begin bad++; $display("[TB] FAIL load_bin got=%h exp=ff", binW); end
        total++; if (outW !== 8'h80) begin bad++; $display("[TB] FAIL load_out got=%h exp=80", outW); end
        load = 1'b0;
        #1;
        total++; if (tcW !== 1'b1) begin bad++; $display("[TB] FAIL wrap_tc got=%b exp=1", tcW); end
        stepEdge();
        total++; if (outW !== 8'h00) begin bad++; $display("[TB] FAIL wrap_out got=%h exp=00", outW); end
        total++; if (binW !== 8'h00) begin bad++; $display("[TB] FAIL wrap_bin got=%h exp=00", binW); end
    endtask

    task automatic test_down_from_reset();
        enable = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0; upDown = 1'b0; enable = 1'b1;
        #1;
        total++; if (tcW !== 1'b1) begin bad++; $display("[TB] FAIL down_tc got=%b exp=1", tcW); end
        stepEdge();
        total++; if (binW !== 8'hFF) begin bad++; $display("[TB] FAIL down_bin got=%h exp=ff", binW); end
        total++; if (outW !== 8'h80) begin bad++; $display("[TB] FAIL down_out got=%h exp=80", outW); end
        total++; if (binS !== 8'h00) begin bad++; $display("[TB] FAIL down_sat_hold got=%h exp=00", binS); end
    endtask

    task automatic test_saturate();
        load = 1'b1; loadVal = 8'hFF; enable = 1'b1; upDown = 1'b1;
        stepEdge();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (tcS !== 1'b1) begin bad++; $display("[TB] FAIL sat_tc step=%0d got=%b exp=1", i, tcS); end
            stepEdge();
            total++; if (binS !== 8'hFF) begin bad++; $display("[TB] FAIL sat_bin step=%0d got=%h exp=ff", i, binS); end
            total++; if (outS !== 8'h80) begin bad++; $display("[TB] FAIL sat_out step=%0d got=%h exp=80", i, outS); end
        end
        upDown = 1'b0;
        #1;
        total++; if (tcS !== 1'b0) begin bad++; $display("[TB] FAIL sat_rev_tc got=%b exp=0", tcS); end
        stepEdge();
        total++; if (binS !== 8'hFE) begin bad++; $display("[TB] FAIL sat_rev_bin got=%h exp=fe", binS); end
        total++; if (outS !== 8'h81) begin bad++; $display("[TB] FAIL sat_rev_out got=%h exp=81", outS); end
    endtask

    task automatic test_direction_change();
        load = 1'b1; loadVal = 8'h10; enable = 1'b1; upDown = 1'b1;
        stepEdge();
        load = 1'b0;
        stepEdge();
        total++; if (binW !== 8'h11) begin bad++; $display("[TB] FAIL dir_up_bin got=%h exp=11", binW); end
        total++; if (outW !== 8'h19) begin bad++; $display("[TB] FAIL dir_up_out got=%h exp=19", outW); end
        upDown = 1'b0;
        stepEdge();
        total++; if (binW !== 8'h10) begin bad++; $display("[TB] FAIL dir_dn_bin got=%h exp=10", binW); end
        total++; if (outW !== 8'h18) begin bad++; $display("[TB] FAIL dir_dn_out got=%h exp=18", outW); end
        stepEdge();
        total++; if (binW !== 8'h0F) begin bad++; $display("[TB] FAIL dir_dn2_bin got=%h exp=0f", binW); end
        total++; if (outW !== 8'h08) begin bad++; $display("[TB] FAIL dir_dn2_out got=%h exp=08", outW); end
    endtask

    task automatic test_tc_gating();
        load = 1'b1; loadVal = 8'hFF; enable = 1'b1; upDown = 1'b1;
        stepEdge();
        load = 1'b0; enable = 1'b0;
        #1;
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL tc_no_enable got=%b exp=0", tcW); end
        load = 1'b1; enable = 1'b1;
        #1;
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL tc_under_load got=%b exp=0", tcW); end
        load = 1'b0; upDown = 1'b0;
        #1;
        total++; if (tcW !== 1'b0) begin bad++; $display("[TB] FAIL tc_wrong_dir got=%b exp=0", tcW); end
        upDown = 1'b1;
        #1;
        total++; if (tcW !== 1'b1) begin bad++; $display("[TB] FAIL tc_at_ff got=%b exp=1", tcW); end
    endtask

    task automatic test_async_reset();
        load = 1'b1; loadVal = 8'h37; enable = 1'b1; upDown = 1'b1;
        stepEdge();
        total++; if (binW !== 8'h37) begin bad++; $display("[TB] FAIL ares_pre_bin got=%h exp=37", binW); end
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++; if (outW !== 8'h00) begin bad++; $display("[TB] FAIL ares_out got=%h exp=00", outW); end
        total++; if (binW !== 8'h00) begin bad++; $display("[TB] FAIL ares_bin got=%h exp=00", binW); end
        total++; if (errW !== 1'b0) begin bad++; $display("[TB] FAIL ares_err got=%b exp=0", errW); end
        stepEdge();
        total++; if (binW !== 8'h00) begin bad++; $display("[TB] FAIL ares_held_bin got=%h exp=00", binW); end
        reset = 1'b0; enable = 1'b0;
    endtask

`ifdef GRAY_CNT_ADJ_CHECK_EN
    logic [7:0] forcedOut;

    task automatic test_adj_checker();
        logic [7:0] prev;
        reset = 1'b1;
        #1;
        reset = 1'b0; enable = 1'b1; upDown = 1'b1; load = 1'b0;
        for (int i = 0; i < 256; i++) begin
            prev = outW;
            stepEdge();
            if ($countones(outW ^ prev) != 1) begin
                total++; bad++;
                $display("[TB] FAIL sweep_onebit step=%0d got=%h prev=%h", i, outW, prev);
            end
        end
        total++; if (errW !== 1'b0) begin bad++; $display("[TB] FAIL sweep_err got=%b exp=0", errW); end
        load = 1'b1; loadVal = 8'h55;
        stepEdge();
        load = 1'b0;
        repeat (3) stepEdge();
        total++; if (errW !== 1'b0) begin bad++; $display("[TB] FAIL load_err got=%b exp=0", errW); end
        enable = 1'b0;
        stepEdge();
        forcedOut = outW ^ 8'h03;
        force dutWrap.out_q = forcedOut;
        stepEdge();
        stepEdge();
        total++; if (errW !== 1'b1) begin bad++; $display("[TB] FAIL force_err got=%b exp=1", errW); end
        release dutWrap.out_q;
        repeat (3) stepEdge();
        total++; if (errW !== 1'b1) begin bad++; $display("[TB] FAIL sticky_err got=%b exp=1", errW); end
        reset = 1'b1;
        #1;
        total++; if (errW !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared got=%b exp=0", errW); end
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_hold();
        test_load_wrap();
        test_down_from_reset();
        test_saturate();
        test_direction_change();
        test_tc_gating();
        test_async_reset();
`ifdef GRAY_CNT_ADJ_CHECK_EN
        test_adj_checker();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
